zeroriscy_multdiv_ctrl: RTL and testbench

ZERORISCY_MULTDIV_CTRL -- requirements
Module: zeroriscy_multdiv_ctrl

---
 rtl/zeroriscy_multdiv_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_zeroriscy_multdiv_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// zeroriscy_multdiv_ctrl
//
// Sequencing wrapper around the iterative multiply/divide unit. It accepts
// one M-extension operation at a time from the decoder and latches it. It then
// enables the multdiv unit until that unit reports a result, and hands the
// result to writeback with a valid/ready handshake. It also owns the shared
// 34-bit adder that the multdiv unit uses for its iterations.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o        decoder request handshake
//   operator_i                       0 MULL, 1 MULH, 2 DIV, 3 REM
//   signed_mode_i                    bit0: op_a signed, bit1: op_b signed
//   op_a_i, op_b_i, rd_addr_i        request operands and destination register
//   flush_i                          kill the in-flight operation
//   md_mult_en_o, md_div_en_o        enables to the multdiv unit
//   md_operator_o, md_signed_mode_o  latched operator / sign mode
//   md_op_a_o, md_op_b_o             latched operands
//   md_alu_operand_a_i/_b_i          adder operands requested by the multdiv unit
//   md_alu_adder_ext_o               full 34-bit adder sum
//   md_alu_adder_o                   md_alu_adder_ext_o[32:1]
//   md_equal_to_zero_o               md_alu_adder_o == 0
//   md_result_i, md_ready_i          multdiv result and its valid strobe
//   wb_valid_o / wb_ready_i          writeback handshake
//   wb_rd_addr_o, wb_data_o          writeback target and data
//   busy_o                           controller is not IDLE
//   timeout_o                        sticky: BUSY/DRAIN lasted TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module zeroriscy_multdiv_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,

  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,

  input  logic [32:0] md_alu_operand_a_i,
  input  logic [32:0] md_alu_operand_b_i,
  output logic [33:0] md_alu_adder_ext_o,
  output logic [31:0] md_alu_adder_o,
  output logic        md_equal_to_zero_o,

  input  logic [31:0] md_result_i,
  input  logic        md_ready_i,

  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,

  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    WB    = 2'd3
  } state_e;

  state_e              state_q, state_d;

  logic [1:0]          operator_p0;
  logic [1:0]          signed_mode_p0;
  logic [DATA_W-1:0]   op_a_p0;
  logic [DATA_W-1:0]   op_b_p0;
  logic [4:0]          rd_addr_p0;
  logic [DATA_W-1:0]   result_p1;

  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;
  logic                timeout_q, timeout_d;
  logic                accept;
  logic                capture;
  logic                in_flight;

  // Saturating increment: the counter parks at its maximum instead of
  // wrapping, so a long hang cannot walk back below the timeout threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) r = v;
    else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared adder: combinational, zero-extended operands, modulo 2^34
  // ---------------------------------------------------------------------------
  assign md_alu_adder_ext_o = {1'b0, md_alu_operand_a_i} + {1'b0, md_alu_operand_b_i};
  assign md_alu_adder_o     = md_alu_adder_ext_o[32:1];
  assign md_equal_to_zero_o = (md_alu_adder_o == '0);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    md_mult_en_o = 1'b0;
    md_div_en_o  = 1'b0;
    wb_valid_o   = 1'b0;
    busy_o       = 1'b1;
    accept       = 1'b0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        // flush_i has nothing to kill here and is deliberately not looked at.
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        md_mult_en_o = ~operator_p0[1];
        md_div_en_o  =  operator_p0[1];
        if (flush_i) begin
          // A result arriving together with the flush is simply dropped.
          state_d = md_ready_i ? IDLE : DRAIN;
        end else if (md_ready_i) begin
          capture = 1'b1;
          state_d = WB;
        end
      end

      DRAIN: begin
        // The multdiv unit cannot be aborted, so keep it enabled until it
        // finishes on its own; its result is thrown away.
        md_mult_en_o = ~operator_p0[1];
        md_div_en_o  =  operator_p0[1];
        if (md_ready_i) state_d = IDLE;
      end

      WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i || flush_i) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Busy counter and sticky timeout
  // ---------------------------------------------------------------------------
  assign in_flight = (state_q == BUSY) || (state_q == DRAIN);

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (accept)         busy_cnt_d = '0;
    else if (in_flight) busy_cnt_d = sat_inc(busy_cnt_q);
  end

  // Compare against the value the counter is about to take, so the flag rises
  // on the same edge that completes the TIMEOUT_CYC-th in-flight cycle.
  assign timeout_d = timeout_q |
                     (in_flight && ({{(32-CNT_W){1'b0}}, busy_cnt_d} >= TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: request latch, loaded only on accept
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operator_p0    <= '0;
      signed_mode_p0 <= '0;
      op_a_p0        <= '0;
      op_b_p0        <= '0;
      rd_addr_p0     <= '0;
    end else if (accept) begin
      operator_p0    <= operator_i;
      signed_mode_p0 <= signed_mode_i;
      op_a_p0        <= op_a_i;
      op_b_p0        <= op_b_i;
      rd_addr_p0     <= rd_addr_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: result register, loaded when BUSY sees md_ready_i without flush
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
    end else if (capture) begin
      result_p1 <= md_result_i;
    end
  end

  assign md_operator_o    = operator_p0;
  assign md_signed_mode_o = signed_mode_p0;
  assign md_op_a_o        = op_a_p0;
  assign md_op_b_o        = op_b_p0;

  // Both writeback fields come from registers, so they hold steady for as
  // long as WB waits on wb_ready_i.
  assign wb_rd_addr_o     = rd_addr_p0;
  assign wb_data_o        = result_p1;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zeroriscy_multdiv_ctrl
//
// Directed bench for zeroriscy_multdiv_ctrl. A behavioural multdiv stub sits
// on the md_* side: it answers after md_lat enabled cycles, or never if
// md_hang is set. It computes the RISC-V M result from the latched operands.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_zeroriscy_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic [32:0] md_alu_operand_a_i;
  logic [32:0] md_alu_operand_b_i;
  logic [33:0] md_alu_adder_ext_o;
  logic [31:0] md_alu_adder_o;
  logic        md_equal_to_zero_o;
  logic [31:0] md_result_i;
  logic        md_ready_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        busy_o;
  logic        timeout_o;

  int          n_chk = 0;
  int          n_err = 0;
  int          md_lat = 2;
  bit          md_hang = 1'b0;
  logic [32:0] tb_alu_a = '0;
  logic [32:0] tb_alu_b = '0;

  always #5 clk = ~clk;

  zeroriscy_multdiv_ctrl #(.TIMEOUT_CYC(40)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .operator_i         (operator_i),
    .signed_mode_i      (signed_mode_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .rd_addr_i          (rd_addr_i),
    .flush_i            (flush_i),
    .md_mult_en_o       (md_mult_en_o),
    .md_div_en_o        (md_div_en_o),
    .md_operator_o      (md_operator_o),
    .md_signed_mode_o   (md_signed_mode_o),
    .md_op_a_o          (md_op_a_o),
    .md_op_b_o          (md_op_b_o),
    .md_alu_operand_a_i (md_alu_operand_a_i),
    .md_alu_operand_b_i (md_alu_operand_b_i),
    .md_alu_adder_ext_o (md_alu_adder_ext_o),
    .md_alu_adder_o     (md_alu_adder_o),
    .md_equal_to_zero_o (md_equal_to_zero_o),
    .md_result_i        (md_result_i),
    .md_ready_i         (md_ready_i),
    .wb_valid_o         (wb_valid_o),
    .wb_ready_i         (wb_ready_i),
    .wb_rd_addr_o       (wb_rd_addr_o),
    .wb_data_o          (wb_data_o),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o)
  );

  // ---------------- multdiv stub ----------------
  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ea, eb, q, r;
    logic signed [65:0] pa, pb, p;
    logic [31:0]        res;
    ea  = sm[0] ? {a[31], a} : {1'b0, a};
    eb  = sm[1] ? {b[31], b} : {1'b0, b};
    pa  = 66'(ea);
    pb  = 66'(eb);
    p   = pa * pb;
    q   = '1;
    r   = ea;
    if (eb != 0) begin
      q = ea / eb;
      r = ea % eb;
    end
    case (op)
      2'd0:    res = p[31:0];
      2'd1:    res = p[63:32];
      2'd2:    res = q[31:0];
      default: res = r[31:0];
    endcase
    return res;
  endfunction

  logic md_en;
  int   md_cnt;
  assign md_en = md_mult_en_o | md_div_en_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   md_cnt <= 0;
    else if (!md_en || md_ready_i) md_cnt <= 0;
    else                          md_cnt <= md_cnt + 1;
  end

  assign md_ready_i  = md_en && !md_hang && (md_cnt == md_lat);
  assign md_result_i = md_model(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
  // While enabled, the stub asks the adder for op_b + 0 so the zero-divisor
  // flag reflects op_b; otherwise the bench drives the adder directly.
  assign md_alu_operand_a_i = md_en ? {md_op_b_o, 1'b0} : tb_alu_a;
  assign md_alu_operand_b_i = md_en ? 33'd0 : tb_alu_b;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input string tag);
    req_valid_i   = 1'b1;
    operator_i    = op;
    signed_mode_i = sm;
    op_a_i        = a;
    op_b_i        = b;
    rd_addr_i     = rd;
    #1;
    check({tag, "_req_ready"}, req_ready_o, 1);
    tick();
    req_valid_i   = 1'b0;
    operator_i    = ~op;
    op_a_i        = ~a;
    op_b_i        = ~b;
    rd_addr_i     = ~rd;
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_op_a"}, md_op_a_o, a);
    check({tag, "_op_b"}, md_op_b_o, b);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 60 && !md_ready_i; i++) tick();
    check({tag, "_md_ready"}, md_ready_i, 1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input string tag);
    logic [1:0] en_exp;
    en_exp     = op[1] ? 2'b01 : 2'b10;
    md_lat     = lat;
    wb_ready_i = 1'b1;
    issue(op, sm, a, b, rd, tag);
    check({tag, "_eq_zero"}, md_equal_to_zero_o, (b == 32'd0));
    check({tag, "_en"}, {md_mult_en_o, md_div_en_o}, en_exp);
    wait_ready(tag);
    check({tag, "_en_at_ready"}, {md_mult_en_o, md_div_en_o}, en_exp);
    check({tag, "_wbv_at_ready"}, wb_valid_o, 0);
    tick();
    check({tag, "_wb_valid"}, wb_valid_o, 1);
    check({tag, "_wb_data"}, wb_data_o, exp);
    check({tag, "_wb_rd"}, wb_rd_addr_o, rd);
    check({tag, "_en_in_wb"}, {md_mult_en_o, md_div_en_o}, 2'b00);
    check({tag, "_rdy_in_wb"}, req_ready_o, 0);
    tick();
    check({tag, "_wb_drop"}, wb_valid_o, 0);
    check({tag, "_idle_ready"}, req_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit wb_seen;
    rst_n         = 1'b0;
    req_valid_i   = 1'b0;
    operator_i    = '0;
    signed_mode_i = '0;
    op_a_i        = '0;
    op_b_i        = '0;
    rd_addr_i     = '0;
    flush_i       = 1'b0;
    wb_ready_i    = 1'b0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_en", {md_mult_en_o, md_div_en_o}, 2'b00);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_op_a", md_op_a_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Shared adder, driven directly while IDLE
    tb_alu_a = 33'd6;  tb_alu_b = 33'd4;  #1;
    check("add_small_ext", md_alu_adder_ext_o, 34'd10);
    check("add_small", md_alu_adder_o, 32'd5);
    check("add_small_eqz", md_equal_to_zero_o, 0);
    tb_alu_a = 33'h1_FFFF_FFFF;  tb_alu_b = 33'd1;  #1;
    check("add_carry_ext", md_alu_adder_ext_o, 34'h2_0000_0000);
    check("add_carry", md_alu_adder_o, 32'h0);
    check("add_carry_eqz", md_equal_to_zero_o, 1);
    tb_alu_a = 33'h1_2345_6789;  tb_alu_b = 33'd1;  #1;
    check("add_mix_ext", md_alu_adder_ext_o, 34'h1_2345_678A);
    check("add_mix", md_alu_adder_o, 32'h91A2_B3C5);
    tick();

    // Basic operations
    run_op(2'd0, 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 2, "mull");
    run_op(2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA, 5, "div_s");
    run_op(2'd3, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFE, 3, "rem_s");
    run_op(2'd2, 2'b00, 32'd9, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, "div_z");
    run_op(2'd3, 2'b00, 32'd9, 32'd0, 5'd13, 32'd9, 1, "rem_z");

    // Flush three cycles after a DIV accept: drain, no writeback
    md_lat = 6;
    wb_ready_i = 1'b1;
    issue(2'd2, 2'b00, 32'd100, 32'd7, 5'd3, "flush");
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("drain_div_en", {md_mult_en_o, md_div_en_o}, 2'b01);
    check("drain_busy", busy_o, 1);
    check("drain_req_ready", req_ready_o, 0);
    wb_seen = 1'b0;
    for (int i = 0; i < 60 && !md_ready_i; i++) begin
      if (wb_valid_o) wb_seen = 1'b1;
      tick();
    end
    check("drain_md_ready", md_ready_i, 1);
    check("drain_en_at_ready", md_div_en_o, 1);
    tick();
    check("drain_exit_ready", req_ready_o, 1);
    check("drain_exit_en", md_div_en_o, 0);
    check("drain_exit_busy", busy_o, 0);
    if (wb_valid_o) wb_seen = 1'b1;
    tick();
    if (wb_valid_o) wb_seen = 1'b1;
    check("drain_no_wb", wb_seen, 0);

    // Flush held through IDLE (ignored) and into BUSY together with md_ready_i
    md_lat = 0;
    flush_i = 1'b1;
    issue(2'd0, 2'b00, 32'd4, 32'd4, 5'd7, "flush_rdy");
    check("flush_rdy_md_ready", md_ready_i, 1);
    tick();
    flush_i = 1'b0;
    check("flush_rdy_idle", req_ready_o, 1);
    check("flush_rdy_no_wb", wb_valid_o, 0);
    check("flush_rdy_busy", busy_o, 0);
    tick();
    check("flush_rdy_no_wb2", wb_valid_o, 0);

    // Flush while waiting in WB
    md_lat = 1;
    wb_ready_i = 1'b0;
    issue(2'd0, 2'b00, 32'd2, 32'd3, 5'd8, "flush_wb");
    wait_ready("flush_wb");
    tick();
    check("flush_wb_valid", wb_valid_o, 1);
    check("flush_wb_data", wb_data_o, 32'd6);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_wb_drop", wb_valid_o, 0);
    check("flush_wb_idle", req_ready_o, 1);

    // Writeback stall with a pending request, then back-to-back MULH
    md_lat = 2;
    wb_ready_i = 1'b0;
    issue(2'd0, 2'b00, 32'd3, 32'd5, 5'd9, "stall");
    wait_ready("stall");
    tick();
    req_valid_i   = 1'b1;
    operator_i    = 2'd1;
    signed_mode_i = 2'b11;
    op_a_i        = 32'h8000_0000;
    op_b_i        = 32'd2;
    rd_addr_i     = 5'd20;
    for (int i = 0; i < 4; i++) begin
      check("stall_wb_valid", wb_valid_o, 1);
      check("stall_wb_data", wb_data_o, 32'd15);
      check("stall_wb_rd", wb_rd_addr_o, 5'd9);
      check("stall_req_ready", req_ready_o, 0);
      check("stall_op_a_held", md_op_a_o, 32'd3);
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    check("hs_req_ready", req_ready_o, 0);
    tick();
    check("hs_idle_ready", req_ready_o, 1);
    check("hs_wb_drop", wb_valid_o, 0);
    tick();
    req_valid_i = 1'b0;
    check("mulh_busy", busy_o, 1);
    check("mulh_operator", md_operator_o, 2'd1);
    check("mulh_op_a", md_op_a_o, 32'h8000_0000);
    check("mulh_mult_en", md_mult_en_o, 1);
    wait_ready("mulh");
    tick();
    check("mulh_wb_valid", wb_valid_o, 1);
    check("mulh_wb_data", wb_data_o, 32'hFFFF_FFFF);
    check("mulh_wb_rd", wb_rd_addr_o, 5'd20);
    tick();
    check("mulh_wb_drop", wb_valid_o, 0);

    run_op(2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 4, "mulhu");
    check("no_timeout_yet", timeout_o, 0);

    // Hung multdiv: timeout, stickiness, then async reset mid-operation
    md_hang = 1'b1;
    issue(2'd2, 2'b11, 32'd50, 32'd5, 5'd30, "hang");
    for (int i = 0; i < 39; i++) tick();
    check("timeout_before", timeout_o, 0);
    tick();
    check("timeout_set", timeout_o, 1);
    for (int i = 0; i < 6; i++) begin
      wb_ready_i = ~wb_ready_i;
      tick();
    end
    check("timeout_sticky", timeout_o, 1);
    check("hang_no_wb", wb_valid_o, 0);
    for (int i = 0; i < 30; i++) tick();
    check("timeout_sat", timeout_o, 1);
    check("hang_busy", busy_o, 1);
    check("hang_div_en", md_div_en_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_timeout", timeout_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_req_ready", req_ready_o, 1);
    check("arst_en", {md_mult_en_o, md_div_en_o}, 2'b00);
    check("arst_op_a", md_op_a_o, 0);
    md_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_no_wb", wb_valid_o, 0);
    check("post_rst_ready", req_ready_o, 1);
    check("post_rst_timeout", timeout_o, 0);

    run_op(2'd0, 2'b00, 32'd11, 32'd13, 5'd1, 32'd143, 2, "post_rst_mull");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
